// File: rtl/gray_pool_28x28_if.sv
// Pixel stream in / pooled-image write bus out for gray_pool_28x28.
// The DUT takes the slave view; whoever feeds pixels and owns the buffer takes master.
interface gray_pool_28x28_if;
  logic       i_PIX_VALID;
  logic       i_SOF;
  logic [7:0] i_GRAYSCALE;
  logic       o_WR_EN;
  logic [9:0] o_WR_ADDR;
  logic [7:0] o_WR_DATA;

  modport master (
    output i_PIX_VALID, i_SOF, i_GRAYSCALE,
    input  o_WR_EN, o_WR_ADDR, o_WR_DATA
  );

  modport slave (
    input  i_PIX_VALID, i_SOF, i_GRAYSCALE,
    output o_WR_EN, o_WR_ADDR, o_WR_DATA
  );
endinterface

// File: rtl/gray_pool_28x28.sv
// Crops a centred 28*BLK square from one grayscale frame per i_START, averages each
// BLK x BLK block (BLK = 1<<BLK_LOG2, 16 in the real system) and writes 784 bytes.
module gray_pool_28x28 #(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int CROP_X0  = 96,
  parameter int CROP_Y0  = 16,
  parameter int INVERT   = 1,
  parameter int BLK_LOG2 = 4
) (
  input  logic                     i_CLK,
  input  logic                     i_RST_n,
  input  logic                     i_START,
  gray_pool_28x28_if.slave         pix_if,
  output logic                     o_BUSY,
  output logic                     o_DONE
);

  localparam int CROP = 28 << BLK_LOG2;
  localparam int XW   = $clog2(IMG_W + 1);
  localparam int YW   = $clog2(IMG_H + 1);
  localparam int AW   = 8 + 2 * BLK_LOG2;
  localparam int OW   = BLK_LOG2 + 5;
  localparam logic [9:0] LAST_ADDR = 10'd783;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE} state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [AW-1:0] acc_q [28];
  logic [AW-1:0] acc_d [28];
  logic          wr_en_q, wr_en_d;
  logic [9:0]    wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;
  logic [OW-1:0] cx, cy;
  logic [4:0]    bx, by;
  logic          in_crop, cap_pix, blk_first, blk_last;
  logic [AW-1:0] sum;
  logic [7:0]    avg;

  // SOF overrides the running counters so the SOF pixel itself is (0,0).
  always_comb begin
    cur_x     = pix_if.i_SOF ? '0 : x_q;
    cur_y     = pix_if.i_SOF ? '0 : y_q;
    in_crop   = (cur_x >= XW'(CROP_X0)) && (cur_x < XW'(CROP_X0 + CROP)) &&
                (cur_y >= YW'(CROP_Y0)) && (cur_y < YW'(CROP_Y0 + CROP));
    cx        = OW'(cur_x - XW'(CROP_X0));
    cy        = OW'(cur_y - YW'(CROP_Y0));
    bx        = cx[OW-1:BLK_LOG2];
    by        = cy[OW-1:BLK_LOG2];
    blk_first = (cx[BLK_LOG2-1:0] == '0) && (cy[BLK_LOG2-1:0] == '0);
    blk_last  = (&cx[BLK_LOG2-1:0]) && (&cy[BLK_LOG2-1:0]);
    cap_pix   = pix_if.i_PIX_VALID && in_crop &&
                ((state_q == S_CAPTURE) || ((state_q == S_ARMED) && pix_if.i_SOF));
    sum       = acc_q[bx] + AW'(pix_if.i_GRAYSCALE);
    avg       = sum[AW-1:2*BLK_LOG2];
  end

  // Raster counters run in every state; past the last line they park until the next SOF.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (pix_if.i_PIX_VALID) begin
      if (cur_y < YW'(IMG_H)) begin
        if (cur_x == XW'(IMG_W - 1)) begin
          x_d = '0;
          y_d = cur_y + YW'(1);
        end else begin
          x_d = cur_x + XW'(1);
          y_d = cur_y;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    busy_d    = (state_q != S_IDLE) || i_START;
    done_d    = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    acc_d     = acc_q;
    case (state_q)
      S_IDLE:    if (i_START) state_d = S_ARMED;
      S_ARMED:   if (pix_if.i_PIX_VALID && pix_if.i_SOF) state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (wr_en_q && (wr_addr_q == LAST_ADDR)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default:   state_d = S_IDLE;
    endcase
    if (cap_pix) begin
      acc_d[bx] = blk_first ? AW'(pix_if.i_GRAYSCALE) : sum;
      if (blk_last) begin
        wr_en_d   = 1'b1;
        wr_addr_d = 10'(by) * 10'd28 + 10'(bx);
        wr_data_d = (INVERT != 0) ? (8'd255 - avg) : avg;
      end
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < 28; i++) acc_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      acc_q     <= acc_d;
    end
  end

  assign pix_if.o_WR_EN   = wr_en_q;
  assign pix_if.o_WR_ADDR = wr_addr_q;
  assign pix_if.o_WR_DATA = wr_data_q;
  assign o_BUSY           = busy_q;
  assign o_DONE           = done_q;

endmodule

// File: tb/tb_gray_pool_28x28.sv
// Directed bench for gray_pool_28x28 on a reduced 64x60 frame with 2x2 blocks (56x56 crop),
// one INVERT=0 and one INVERT=1 instance sharing the same stimulus.
module tb_gray_pool_28x28;
  localparam int IMG_W = 64;
  localparam int IMG_H = 60;
  localparam int CX0   = 6;
  localparam int CY0   = 3;
  localparam int BL    = 1;
  localparam int BLK   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       pv = 1'b0;
  logic       sof_v = 1'b0;
  logic [7:0] pix_v = 8'd0;
  logic       busy0, done0, busy1, done1;
  logic       clr = 1'b0;

  int nchk = 0;
  int npass = 0;
  int nfail = 0;
  int cyc = 0;

  int mem0 [784];
  int mem1 [784];
  int wcnt0 = 0, wcnt1 = 0, order_err = 0, first_addr = -1, last_addr = -1;
  int done_cnt = 0, done_cyc = -1, wr783_cyc = -2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gray_pool_28x28_if if0 ();
  gray_pool_28x28_if if1 ();

  assign if0.i_PIX_VALID = pv;
  assign if0.i_SOF       = sof_v;
  assign if0.i_GRAYSCALE = pix_v;
  assign if1.i_PIX_VALID = pv;
  assign if1.i_SOF       = sof_v;
  assign if1.i_GRAYSCALE = pix_v;

  gray_pool_28x28 #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CROP_X0(CX0), .CROP_Y0(CY0),
                    .INVERT(0), .BLK_LOG2(BL)) dut0 (
    .i_CLK(clk), .i_RST_n(rst_n), .i_START(start), .pix_if(if0.slave),
    .o_BUSY(busy0), .o_DONE(done0));

  gray_pool_28x28 #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CROP_X0(CX0), .CROP_Y0(CY0),
                    .INVERT(1), .BLK_LOG2(BL)) dut1 (
    .i_CLK(clk), .i_RST_n(rst_n), .i_START(start), .pix_if(if1.slave),
    .o_BUSY(busy1), .o_DONE(done1));

  // Write/done monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (clr) begin
      wcnt0 = 0; wcnt1 = 0; order_err = 0; first_addr = -1; last_addr = -1;
      done_cnt = 0; done_cyc = -1; wr783_cyc = -2;
      for (int i = 0; i < 784; i++) begin
        mem0[i] = -1;
        mem1[i] = -1;
      end
    end else begin
      if (if0.o_WR_EN) begin
        if (wcnt0 == 0) first_addr = int'(if0.o_WR_ADDR);
        else if (int'(if0.o_WR_ADDR) <= last_addr) order_err++;
        last_addr = int'(if0.o_WR_ADDR);
        if (if0.o_WR_ADDR < 10'd784) mem0[if0.o_WR_ADDR] = int'(if0.o_WR_DATA);
        if (if0.o_WR_ADDR == 10'd783) wr783_cyc = cyc;
        wcnt0++;
      end
      if (if1.o_WR_EN) begin
        if (if1.o_WR_ADDR < 10'd784) mem1[if1.o_WR_ADDR] = int'(if1.o_WR_DATA);
        wcnt1++;
      end
      if (done0) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  function automatic int pixval(input int mode, input int x, input int y);
    case (mode)
      0:       return 200;
      1:       return (x >= 12 && x <= 13 && y >= 13 && y <= 14) ? 255 : 0;
      2:       return (x >= CX0 && x < CX0 + BLK && y >= CY0 && y < CY0 + BLK) ? ((x + y) & 1) : 0;
      3:       return (x >= CX0 && x < CX0 + BLK && y >= CY0 && y < CY0 + BLK) ? 1 : 0;
      default: return (x * 7 + y * 13) & 255;
    endcase
  endfunction

  function automatic int exp_val(input int mode, input int bx, input int by, input bit inv);
    int s = 0;
    for (int dy = 0; dy < BLK; dy++)
      for (int dx = 0; dx < BLK; dx++)
        s += pixval(mode, CX0 + bx * BLK + dx, CY0 + by * BLK + dy);
    s = s >> (2 * BL);
    return inv ? 255 - s : s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear();
    @(posedge clk); clr = 1'b1;
    @(posedge clk); clr = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic frame(input int mode, input int nlines, input bit gaps, input bit start_sof);
    for (int y = 0; y < nlines; y++) begin
      for (int x = 0; x < IMG_W; x++) begin
        if (gaps) begin
          while ($urandom_range(1, 0) == 1) begin
            @(negedge clk); pv = 1'b0; sof_v = 1'b0;
            if (start_sof) start = 1'b0;
          end
        end
        @(negedge clk);
        pv    = 1'b1;
        sof_v = (x == 0 && y == 0);
        pix_v = 8'(pixval(mode, x, y));
        if (start_sof) start = (x == 0 && y == 0);
      end
    end
    @(negedge clk); pv = 1'b0; sof_v = 1'b0;
    if (start_sof) start = 1'b0;
  endtask

  task automatic capture_checks(input string tag, input int mode);
    int bad0 = 0;
    int bad1 = 0;
    for (int a = 0; a < 784; a++) begin
      if (mem0[a] != exp_val(mode, a % 28, a / 28, 1'b0)) bad0++;
      if (mem1[a] != exp_val(mode, a % 28, a / 28, 1'b1)) bad1++;
    end
    chk({tag, "_wcnt0"}, wcnt0, 784);
    chk({tag, "_wcnt1"}, wcnt1, 784);
    chk({tag, "_order"}, order_err, 0);
    chk({tag, "_first"}, first_addr, 0);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_done_lat"}, done_cyc - wr783_cyc, 1);
    chk({tag, "_data0_bad"}, bad0, 0);
    chk({tag, "_data1_bad"}, bad1, 0);
    chk({tag, "_busy_end"}, busy0, 0);
  endtask

  initial begin
    for (int i = 0; i < 784; i++) begin
      mem0[i] = -1;
      mem1[i] = -1;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", if0.o_WR_EN, 0);
    chk("rst_wr_addr", if0.o_WR_ADDR, 0);
    chk("rst_wr_data", if1.o_WR_DATA, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done1, 0);
    rst_n = 1'b1;
    clear();

    // A frame without a request produces nothing.
    frame(0, IMG_H, 1'b0, 1'b0);
    chk("prestart_wcnt", wcnt0, 0);
    chk("prestart_done", done_cnt, 0);
    chk("prestart_busy", busy0, 0);

    // Constant 200; extra STARTs while armed and mid-capture are ignored.
    clear();
    pulse_start();
    chk("start_busy", busy0, 1);
    pulse_start();
    fork
      frame(0, IMG_H, 1'b0, 1'b0);
      begin
        repeat (1500) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
      end
    join
    capture_checks("const", 0);
    chk("const_addr0", mem0[0], 200);
    chk("const_inv_addr783", mem1[783], 55);

    // Single bright block at bx=3, by=5.
    clear();
    pulse_start();
    frame(1, IMG_H, 1'b0, 1'b0);
    capture_checks("block", 1);
    chk("block_addr143", mem0[143], 255);
    chk("block_addr142", mem0[142], 0);

    // Checkerboard in block (0,0) truncates to 0.
    clear();
    pulse_start();
    frame(2, IMG_H, 1'b0, 1'b0);
    capture_checks("checker", 2);
    chk("checker_addr0", mem0[0], 0);
    chk("checker_inv_addr0", mem1[0], 255);

    // START coincident with SOF in IDLE only arms; the next frame is captured.
    clear();
    frame(3, IMG_H, 1'b0, 1'b1);
    chk("startsof_wcnt", wcnt0, 0);
    chk("startsof_busy", busy0, 1);
    frame(3, IMG_H, 1'b0, 1'b0);
    capture_checks("ones", 3);
    chk("ones_addr0", mem0[0], 1);

    // Abort: partial frame then a new SOF restarts the capture.
    clear();
    pulse_start();
    frame(5, 20, 1'b0, 1'b0);
    chk("abort_partial_wr", wcnt0 > 0, 1);
    chk("abort_partial_done", done_cnt, 0);
    clear();
    frame(5, IMG_H, 1'b0, 1'b0);
    capture_checks("abort", 5);

    // Random valid gaps give the same image.
    clear();
    pulse_start();
    frame(5, IMG_H, 1'b1, 1'b0);
    capture_checks("gaps", 5);

    // Reset mid-capture.
    clear();
    pulse_start();
    frame(0, 30, 1'b0, 1'b0);
    chk("midrst_busy_before", busy0, 1);
    chk("midrst_wr_before", wcnt0 > 0, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy0, 0);
    chk("midrst_wr_addr", if0.o_WR_ADDR, 0);
    chk("midrst_wr_data", if0.o_WR_DATA, 0);
    chk("midrst_done_cnt", done_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear();
    frame(0, IMG_H, 1'b0, 1'b0);
    chk("postrst_wcnt", wcnt0, 0);
    chk("postrst_done", done_cnt, 0);
    chk("postrst_busy", busy0, 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
